// File: rtl/i2c_mem_pkg.sv
// ============================================================================
// Module      : i2c_mem_pkg
// Description : Shared FSM state codes and bus constants for the I2C slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_mem_pkg;

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_DEV_ADDR  = 4'd1;
    localparam logic [3:0] c_ST_ACK_HDR   = 4'd2;
    localparam logic [3:0] c_ST_DEV_ADDR2 = 4'd3;
    localparam logic [3:0] c_ST_ACK_DEV   = 4'd4;
    localparam logic [3:0] c_ST_MEM_ADDR  = 4'd5;
    localparam logic [3:0] c_ST_ACK_MEM   = 4'd6;
    localparam logic [3:0] c_ST_WR_DATA   = 4'd7;
    localparam logic [3:0] c_ST_ACK_WR    = 4'd8;
    localparam logic [3:0] c_ST_RD_DATA   = 4'd9;
    localparam logic [3:0] c_ST_RD_ACK    = 4'd10;
    localparam logic [3:0] c_ST_IGNORE    = 4'd11;

    localparam logic [4:0] c_HDR10 = 5'b11110;

    // SDA line levels for the acknowledge bit
    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronisers with edge, START and STOP event detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    // SCL must be high on both samples so an SDA edge racing SCL is not a START/STOP
    assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_mem_sync.sv
// ============================================================================
// Module      : i2c_slave_mem_sync
// Description : Oversampled I2C slave EEPROM model, 7/10-bit addressing, page wrap, WP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_mem_sync
    import i2c_mem_pkg::*;
#(
    parameter int MEM_DEPTH     = 4096,
    parameter int ADDRESS_BYTES = 2,
    parameter int PAGE_SIZE     = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [9:0] dev_addr,
    input  logic       addr10_en,
    input  logic       wp,
    output logic       busy,
    output logic       wr_pulse
);

    localparam int              c_AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_AW-1:0] c_PAGE_MASK = (PAGE_SIZE == 0) ? {c_AW{1'b1}} : c_AW'(PAGE_SIZE - 1);

    logic [3:0]      r_state;
    logic [2:0]      r_bit_cnt;
    logic            r_byte_done;
    logic [7:0]      r_shift;
    logic [7:0]      r_tx;
    logic            r_rw;
    logic            r_matched10;
    logic [1:0]      r_abytes;
    logic [c_AW-1:0] r_ptr;
    logic            r_mack;
    logic            r_sda_oe;
    logic            r_busy;
    logic            r_wr_pulse;
    logic [7:0]      r_mem [MEM_DEPTH];

    logic            w_sda;
    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic            w_shifting;
    logic            w_byte_fall;
    logic            w_hdr_match;
    logic            w_dev7_match;
    logic            w_wr_en;
    logic [7:0]      w_rd_byte;
    logic [c_AW+7:0] w_ptr_cat;
    logic [c_AW-1:0] w_ptr_wr_next;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_shifting    = (r_state == c_ST_DEV_ADDR) || (r_state == c_ST_DEV_ADDR2) ||
                           (r_state == c_ST_MEM_ADDR) || (r_state == c_ST_WR_DATA);
    assign w_byte_fall   = w_scl_fall & r_byte_done;
    assign w_hdr_match   = (r_shift[7:3] == c_HDR10) && (r_shift[2:1] == dev_addr[9:8]);
    // 7'h00 is the general call and is never claimed
    assign w_dev7_match  = (r_shift[7:1] == dev_addr[6:0]) && (r_shift[7:1] != 7'd0);
    assign w_rd_byte     = r_mem[r_ptr];
    assign w_ptr_cat     = {r_ptr, r_shift};
    // Only the in-page bits count up, so a burst wraps inside its page
    assign w_ptr_wr_next = (r_ptr & ~c_PAGE_MASK) | ((r_ptr + c_PTR_ONE) & c_PAGE_MASK);
    assign w_wr_en       = !rst && !w_start && !w_stop && (r_state == c_ST_WR_DATA) && w_byte_fall && !wp;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_shift     <= 8'd0;
            r_tx        <= 8'd0;
            r_rw        <= 1'b0;
            r_matched10 <= 1'b0;
            r_abytes    <= 2'd0;
            r_ptr       <= '0;
            r_mack      <= c_NACK;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_pulse  <= 1'b0;
        end else begin
            r_wr_pulse <= w_wr_en;
            if (w_stop) begin
                r_state     <= c_ST_IDLE;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
                r_matched10 <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_start) begin
                r_state     <= c_ST_DEV_ADDR;
                r_bit_cnt   <= 3'd7;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                if (w_scl_rise && w_shifting) begin
                    r_shift <= {r_shift[6:0], w_sda};
                    if (r_bit_cnt == 3'd0) begin
                        r_byte_done <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                case (r_state)
                    c_ST_DEV_ADDR: begin
                        if (w_byte_fall) begin
                            r_byte_done <= 1'b0;
                            r_bit_cnt   <= 3'd7;
                            r_matched10 <= 1'b0;
                            r_state     <= c_ST_IGNORE;
                            if (!addr10_en && w_dev7_match) begin
                                r_state  <= c_ST_ACK_DEV;
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                            end else if (addr10_en && w_hdr_match && !r_shift[0]) begin
                                r_state  <= c_ST_ACK_HDR;
                                r_sda_oe <= 1'b1;
                            end else if (addr10_en && w_hdr_match && r_matched10) begin
                                r_state     <= c_ST_ACK_DEV;
                                r_rw        <= 1'b1;
                                r_matched10 <= 1'b1;
                                r_sda_oe    <= 1'b1;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    c_ST_ACK_HDR: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd7;
                            r_state   <= c_ST_DEV_ADDR2;
                        end
                    end
                    c_ST_DEV_ADDR2: begin
                        if (w_byte_fall) begin
                            r_byte_done <= 1'b0;
                            if (r_shift == dev_addr[7:0]) begin
                                r_state     <= c_ST_ACK_DEV;
                                r_rw        <= 1'b0;
                                r_matched10 <= 1'b1;
                                r_sda_oe    <= 1'b1;
                                r_busy      <= 1'b1;
                            end else begin
                                r_state <= c_ST_IGNORE;
                            end
                        end
                    end
                    c_ST_ACK_DEV: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd7;
                            if (r_rw) begin
                                r_sda_oe <= ~w_rd_byte[7];
                                r_tx     <= {w_rd_byte[6:0], 1'b0};
                                r_state  <= c_ST_RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_abytes <= 2'(ADDRESS_BYTES);
                                r_state  <= c_ST_MEM_ADDR;
                            end
                        end
                    end
                    c_ST_MEM_ADDR: begin
                        if (w_byte_fall) begin
                            r_byte_done <= 1'b0;
                            r_ptr       <= w_ptr_cat[c_AW-1:0];
                            r_abytes    <= r_abytes - 2'd1;
                            r_sda_oe    <= 1'b1;
                            r_state     <= c_ST_ACK_MEM;
                        end
                    end
                    c_ST_ACK_MEM: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd7;
                            r_state   <= (r_abytes == 2'd0) ? c_ST_WR_DATA : c_ST_MEM_ADDR;
                        end
                    end
                    c_ST_WR_DATA: begin
                        if (w_byte_fall) begin
                            r_byte_done <= 1'b0;
                            r_state     <= c_ST_ACK_WR;
                            if (!wp) begin
                                r_ptr    <= w_ptr_wr_next;
                                r_sda_oe <= 1'b1;
                            end
                        end
                    end
                    c_ST_ACK_WR: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd7;
                            r_state   <= c_ST_WR_DATA;
                        end
                    end
                    c_ST_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= c_ST_RD_ACK;
                            end else begin
                                r_sda_oe  <= ~r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    c_ST_RD_ACK: begin
                        // Pointer advances on the ACK sample so a NACK+STOP still leaves it moved
                        if (w_scl_rise) begin
                            r_mack      <= w_sda;
                            r_ptr       <= r_ptr + c_PTR_ONE;
                            r_byte_done <= 1'b1;
                        end else if (w_byte_fall) begin
                            r_byte_done <= 1'b0;
                            if (r_mack == c_ACK) begin
                                r_sda_oe  <= ~w_rd_byte[7];
                                r_tx      <= {w_rd_byte[6:0], 1'b0};
                                r_bit_cnt <= 3'd7;
                                r_state   <= c_ST_RD_DATA;
                            end else begin
                                r_state <= c_ST_IGNORE;
                            end
                        end
                    end
                    c_ST_IDLE, c_ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= c_ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_pulse = r_wr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_mem_sync.sv
// ============================================================================
// Module      : tb_i2c_slave_mem_sync
// Description : Bit-banged I2C master bench with scoreboard for i2c_slave_mem_sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_mem_sync;

    localparam int Q = 5;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        logic       a10;
        logic [9:0] dev;
        logic [7:0] b;
        logic       ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       busy;
    logic       wr_pulse;
    logic [9:0] dev_addr = 10'h050;
    logic       addr10_en = 1'b0;
    logic       wp = 1'b0;

    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    logic oe_seen = 1'b0;
    exp_t sb_q[$];
    vec_t vt[8];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_mem_sync dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (m_scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .dev_addr  (dev_addr),
        .addr10_en (addr10_en),
        .wp        (wp),
        .busy      (busy),
        .wr_pulse  (wr_pulse)
    );

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) pulses++;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic sb_push(input string n, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [7:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got %0h expected queued value", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, 16'(act), 16'(e.val));
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait(Q);
        m_scl = 1'b1; qwait(Q);
        m_sda = 1'b0; qwait(Q);
        m_scl = 1'b0; qwait(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait(Q);
        m_scl = 1'b1; qwait(Q);
        m_sda = 1'b1; qwait(2 * Q);
    endtask

    task automatic wbit(input logic b);
        m_sda = b;    qwait(Q);
        m_scl = 1'b1; qwait(2 * Q);
        m_scl = 1'b0; qwait(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; qwait(Q);
        m_scl = 1'b1; qwait(Q);
        b = sda_bus;  qwait(Q);
        m_scl = 1'b0; qwait(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string n);
        logic s;
        sb_push(n, {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(s);
        sb_pop({7'd0, ~s});
    endtask

    task automatic rd_byte(input logic mack, input logic [7:0] exp, input string n);
        logic       s;
        logic [7:0] d;
        d = 8'd0;
        sb_push(n, exp);
        for (int i = 0; i < 8; i++) begin
            rbit(s);
            d = {d[6:0], s};
        end
        wbit(~mack);
        sb_pop(d);
    endtask

    task automatic set_ptr7(input logic [15:0] a, input string n);
        i2c_start();
        wr_byte(8'hA0, 1'b1, {n, "_dev"});
        wr_byte(a[15:8], 1'b1, {n, "_ahi"});
        wr_byte(a[7:0], 1'b1, {n, "_alo"});
    endtask

    task automatic mem_write7(input logic [15:0] a, input logic [7:0] d, input string n);
        set_ptr7(a, n);
        wr_byte(d, 1'b1, {n, "_data"});
        i2c_stop();
    endtask

    task automatic mem_read7(input logic [15:0] a, input int nb, input logic [7:0] e0,
                             input logic [7:0] e1, input string n);
        set_ptr7(a, n);
        i2c_start();
        wr_byte(8'hA1, 1'b1, {n, "_rdev"});
        if (nb == 2) begin
            rd_byte(1'b1, e0, {n, "_rd0"});
            rd_byte(1'b0, e1, {n, "_rd1"});
        end else begin
            rd_byte(1'b0, e0, {n, "_rd0"});
        end
        i2c_stop();
    endtask

    initial begin
        int   p0;
        logic s;

        vt[0] = '{1'b0, 10'h050, 8'hA0, 1'b1};
        vt[1] = '{1'b0, 10'h050, 8'hA2, 1'b0};
        vt[2] = '{1'b0, 10'h000, 8'h00, 1'b0};
        vt[3] = '{1'b1, 10'h2C5, 8'hF4, 1'b1};
        vt[4] = '{1'b1, 10'h2C5, 8'hF6, 1'b0};
        vt[5] = '{1'b1, 10'h2C5, 8'hF5, 1'b0};
        vt[6] = '{1'b1, 10'h050, 8'hA0, 1'b0};
        vt[7] = '{1'b0, 10'h001, 8'h02, 1'b1};

        qwait(4);
        check("rst_sda_oe", 16'(sda_oe), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_wr_pulse", 16'(wr_pulse), 16'd0);
        rst = 1'b0;
        qwait(4);

        // Device-address acceptance table
        for (int i = 0; i < 8; i++) begin
            addr10_en = vt[i].a10;
            dev_addr  = vt[i].dev;
            i2c_start();
            wr_byte(vt[i].b, vt[i].ack, $sformatf("vec%0d_ack", i));
            i2c_stop();
        end

        addr10_en = 1'b0;
        dev_addr  = 10'h050;
        mem_write7(16'h0125, 8'h3C, "pre125");

        // 7-bit two-byte write
        p0 = pulses;
        i2c_start();
        wr_byte(8'hA0, 1'b1, "a_dev");
        check("a_busy_hi", 16'(busy), 16'd1);
        wr_byte(8'h01, 1'b1, "a_ahi");
        wr_byte(8'h23, 1'b1, "a_alo");
        wr_byte(8'hA5, 1'b1, "a_d0");
        wr_byte(8'h5A, 1'b1, "a_d1");
        i2c_stop();
        check("a_busy_lo", 16'(busy), 16'd0);
        check("a_pulses", 16'(pulses - p0), 16'd2);

        // Random read then current-address read
        mem_read7(16'h0123, 2, 8'hA5, 8'h5A, "b_rand");
        i2c_start();
        wr_byte(8'hA1, 1'b1, "b_cur_dev");
        rd_byte(1'b0, 8'h3C, "b_cur_data");
        i2c_stop();

        // Page wrap
        set_ptr7(16'h001E, "c");
        wr_byte(8'h01, 1'b1, "c_d1");
        wr_byte(8'h02, 1'b1, "c_d2");
        wr_byte(8'h03, 1'b1, "c_d3");
        wr_byte(8'h04, 1'b1, "c_d4");
        i2c_stop();
        mem_read7(16'h001E, 2, 8'h01, 8'h02, "c_rd1e");
        mem_read7(16'h0000, 2, 8'h03, 8'h04, "c_rd00");

        // 10-bit write and repeated-start read
        addr10_en = 1'b1;
        dev_addr  = 10'h2C5;
        i2c_start();
        wr_byte(8'hF4, 1'b1, "d_hdr");
        wr_byte(8'hC5, 1'b1, "d_lo");
        wr_byte(8'h00, 1'b1, "d_ahi");
        wr_byte(8'h10, 1'b1, "d_alo");
        wr_byte(8'h99, 1'b1, "d_data");
        i2c_stop();
        i2c_start();
        wr_byte(8'hF4, 1'b1, "d_rhdr");
        wr_byte(8'hC5, 1'b1, "d_rlo");
        wr_byte(8'h00, 1'b1, "d_rahi");
        wr_byte(8'h10, 1'b1, "d_ralo");
        i2c_start();
        wr_byte(8'hF5, 1'b1, "d_rdhdr");
        rd_byte(1'b0, 8'h99, "d_rdata");
        i2c_stop();
        dev_addr = 10'h2C6;
        i2c_start();
        wr_byte(8'hF4, 1'b1, "d_x_hdr");
        oe_seen = 1'b0;
        wr_byte(8'hC5, 1'b0, "d_x_lo");
        i2c_stop();
        check("d_x_oe_quiet", 16'(oe_seen), 16'd0);

        // Write protect
        addr10_en = 1'b0;
        dev_addr  = 10'h050;
        mem_write7(16'h0200, 8'h11, "e_pre");
        wp = 1'b1;
        p0 = pulses;
        set_ptr7(16'h0200, "e");
        wr_byte(8'h77, 1'b0, "e_nack");
        i2c_stop();
        check("e_pulses", 16'(pulses - p0), 16'd0);
        wp = 1'b0;
        mem_read7(16'h0200, 1, 8'h11, 8'h00, "e_rd");

        // STOP in the middle of a data byte
        p0 = pulses;
        set_ptr7(16'h0200, "f");
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop();
        check("f_busy", 16'(busy), 16'd0);
        check("f_pulses", 16'(pulses - p0), 16'd0);
        mem_read7(16'h0200, 1, 8'h11, 8'h00, "f_rd");

        // Read wraps at the top of memory
        mem_write7(16'h0FFF, 8'hE1, "g_pre");
        mem_read7(16'h0FFF, 2, 8'hE1, 8'h03, "g_wrap");

        // Reset while driving read data
        set_ptr7(16'h001F, "h");
        i2c_start();
        wr_byte(8'hA1, 1'b1, "h_rdev");
        rbit(s);
        check("h_bit7", 16'(s), 16'd0);
        check("h_driving", 16'(sda_oe), 16'd1);
        rst = 1'b1;
        qwait(1);
        check("h_rst_sda_oe", 16'(sda_oe), 16'd0);
        check("h_rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        qwait(2);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA1, 1'b1, "h_cur_dev");
        rd_byte(1'b0, 8'h03, "h_cur_ptr0");
        i2c_stop();

        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
